// File: rtl/regwb_queue.sv
// Write-back queue: collects ALU and load results in an in-order FIFO and retires one per cycle
// to the register-file write port, with youngest-match forwarding over queued entries.
module regwb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          ld_valid,
  input  logic [4:0]    ld_rd,
  input  logic [31:0]   ld_data,
  output logic          in_ready,
  output logic [4:0]    Rw,
  output logic [31:0]   busW,
  output logic          RegWr,
  input  logic [4:0]    Ra,
  input  logic [4:0]    Rb,
  output logic          fwdA_hit,
  output logic [31:0]   fwdA_data,
  output logic          fwdB_hit,
  output logic [31:0]   fwdB_data,
  output logic [AW:0]   pending,
  output logic          ovf_err
);

  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [4:0]    ent_rd_q   [DEPTH];
  logic [4:0]    ent_rd_d   [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];

  logic          ld_ok, alu_ok, pop;
  logic [1:0]    enq_cnt;
  logic [AW-1:0] alu_idx;
  logic [AW-1:0] scan_idx;

  // Admission and pointer bookkeeping
  always_comb begin
    in_ready = (count_q <= CW'(DEPTH - 2));
    pop      = (count_q != '0);
    ld_ok    = ld_valid  && (ld_rd  != 5'd0);
    alu_ok   = alu_valid && (alu_rd != 5'd0);
    enq_cnt  = 2'd0;
    alu_idx  = wptr_q + AW'(ld_ok);
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    ovf_d    = ovf_q | (!in_ready && (alu_valid || ld_valid));
    if (in_ready) begin
      // The load is the older instruction, so it takes the first free slot.
      if (ld_ok) begin
        ent_rd_d[wptr_q]   = ld_rd;
        ent_data_d[wptr_q] = ld_data;
      end
      if (alu_ok) begin
        ent_rd_d[alu_idx]   = alu_rd;
        ent_data_d[alu_idx] = alu_data;
      end
      enq_cnt = {1'b0, ld_ok} + {1'b0, alu_ok};
    end
    wptr_d  = wptr_q + AW'(enq_cnt);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(enq_cnt) - CW'(pop);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge Clk) begin
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

  // Drain port driven straight from the head entry
  always_comb begin
    RegWr = pop;
    Rw    = pop ? ent_rd_q[rptr_q]   : 5'd0;
    busW  = pop ? ent_data_q[rptr_q] : 32'd0;
  end

  // Forwarding: scan oldest to youngest so the last match overrides earlier ones.
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdA_data = 32'd0;
    fwdB_hit  = 1'b0;
    fwdB_data = 32'd0;
    scan_idx  = rptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rptr_q + AW'(k);
      if (CW'(k) < count_q) begin
        if ((Ra != 5'd0) && (ent_rd_q[scan_idx] == Ra)) begin
          fwdA_hit  = 1'b1;
          fwdA_data = ent_data_q[scan_idx];
        end
        if ((Rb != 5'd0) && (ent_rd_q[scan_idx] == Rb)) begin
          fwdB_hit  = 1'b1;
          fwdB_data = ent_data_q[scan_idx];
        end
      end
    end
  end

  assign pending = count_q;
  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_regwb_queue.sv
// Bench for regwb_queue: directed vector table, hand-written overflow/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_regwb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0, Ra = '0, Rb = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        in_ready, RegWr, fwdA_hit, fwdB_hit, ovf_err;
  logic [4:0]  Rw;
  logic [31:0] busW, fwdA_data, fwdB_data;
  logic [AW:0] pending;

  regwb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .in_ready(in_ready), .Rw(Rw), .busW(busW), .RegWr(RegWr),
    .Ra(Ra), .Rb(Rb),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
    .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data),
    .pending(pending), .ovf_err(ovf_err)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a plain queue of {rd, data}, head at index 0.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];
  bit   movf = 0;

  task automatic model_edge();
    bit rdy;
    rdy = (mq.size() <= DEPTH - 2);
    if (mq.size() != 0) void'(mq.pop_front());
    if (rdy) begin
      if (ld_valid && ld_rd != 0)   mq.push_back('{ld_rd, ld_data});
      if (alu_valid && alu_rd != 0) mq.push_back('{alu_rd, alu_data});
    end else if (alu_valid || ld_valid) begin
      movf = 1;
    end
  endtask

  task automatic fwd_lookup(input logic [4:0] r, output bit hit, output logic [31:0] d);
    hit = 0;
    d = 32'd0;
    if (r != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == r) begin
          hit = 1;
          d = mq[i].data;
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    bit          ha, hb;
    logic [31:0] da, db;
    bit          ne;
    ne = (mq.size() != 0);
    fwd_lookup(Ra, ha, da);
    fwd_lookup(Rb, hb, db);
    chk("rnd_RegWr", 32'(RegWr), 32'(ne));
    chk("rnd_Rw", 32'(Rw), ne ? 32'(mq[0].rd) : 32'd0);
    chk("rnd_busW", busW, ne ? mq[0].data : 32'd0);
    chk("rnd_pending", 32'(pending), 32'(mq.size()));
    chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() <= DEPTH - 2));
    chk("rnd_ovf", 32'(ovf_err), 32'(movf));
    chk("rnd_fwdA_hit", 32'(fwdA_hit), 32'(ha));
    chk("rnd_fwdA_data", fwdA_data, da);
    chk("rnd_fwdB_hit", 32'(fwdB_hit), 32'(hb));
    chk("rnd_fwdB_data", fwdB_data, db);
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
  endtask

  task automatic advance();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    bit av; logic [4:0] ard; logic [31:0] adat;
    bit lv; logic [4:0] lrd; logic [31:0] ldat;
    logic [4:0] ra; logic [4:0] rb;
    bit e_wr; logic [4:0] e_rw; logic [31:0] e_busw; int e_pend;
    bit e_ha; logic [31:0] e_da; bit e_hb; logic [31:0] e_db; bit e_rdy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Outputs listed are the values seen during the row's cycle, before the row's inputs are taken.
    tbl[0]  = '{0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[1]  = '{1, 5, 32'hAA,       0, 0, 0,     5, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[2]  = '{0, 0, 0,            0, 0, 0,     5, 5,  1, 5, 32'hAA, 1, 1, 32'hAA, 1, 32'hAA, 1};
    tbl[3]  = '{1, 4, 32'h22,       1, 3, 32'h11, 5, 0, 0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[4]  = '{0, 0, 0,            0, 0, 0,     4, 3,  1, 3, 32'h11, 2, 1, 32'h22, 1, 32'h11, 1};
    tbl[5]  = '{0, 0, 0,            0, 0, 0,     3, 4,  1, 4, 32'h22, 1, 0, 0,     1, 32'h22, 1};
    tbl[6]  = '{1, 7, 32'h2,        1, 7, 32'h1, 7, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,     7, 0,  1, 7, 32'h1, 2, 1, 32'h2, 0, 0,     1};
    tbl[8]  = '{0, 0, 0,            0, 0, 0,     7, 7,  1, 7, 32'h2, 1, 1, 32'h2, 1, 32'h2, 1};
    tbl[9]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,     7, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[10] = '{0, 0, 0,            0, 0, 0,     7, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[11] = '{1, 0, 32'hFFFFFFFF, 1, 0, 32'h5, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};
    tbl[12] = '{0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,     0, 0, 0,     0, 0,     1};

    // Power-on reset
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_RegWr", 32'(RegWr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
      Ra = tbl[i].ra;
      Rb = tbl[i].rb;
      #1;
      chk($sformatf("v%0d_RegWr", i), 32'(RegWr), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_Rw", i), 32'(Rw), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_busW", i), busW, tbl[i].e_busw);
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d_fwdA_hit", i), 32'(fwdA_hit), 32'(tbl[i].e_ha));
      chk($sformatf("v%0d_fwdA_data", i), fwdA_data, tbl[i].e_da);
      chk($sformatf("v%0d_fwdB_hit", i), 32'(fwdB_hit), 32'(tbl[i].e_hb));
      chk($sformatf("v%0d_fwdB_data", i), fwdB_data, tbl[i].e_db);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_err), 32'd0);
      advance();
    end
    Ra = 0; Rb = 0;

    // Overflow: fill to 3 entries, then offer rd=9 while full
    drive(1, 2, 32'h200, 1, 1, 32'h100);
    advance();
    drive(1, 4, 32'h400, 1, 3, 32'h300);
    advance();
    drive(1, 9, 32'h900, 0, 0, 0);
    #1;
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_pending3", 32'(pending), 32'd3);
    chk("ovf_before", 32'(ovf_err), 32'd0);
    chk("ovf_head2", 32'(Rw), 32'd2);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("ovf_head3", 32'(Rw), 32'd3);
    chk("ovf_pending2", 32'(pending), 32'd2);
    advance();
    chk("ovf_head4", 32'(Rw), 32'd4);
    chk("ovf_busW4", busW, 32'h400);
    advance();
    chk("ovf_drained_wr", 32'(RegWr), 32'd0);
    chk("ovf_drained_rw", 32'(Rw), 32'd0);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    advance();
    chk("ovf_sticky2", 32'(ovf_err), 32'd1);

    // Asynchronous reset with 3 entries queued
    drive(1, 2, 32'h2, 1, 1, 32'h1);
    advance();
    drive(1, 4, 32'h4, 1, 3, 32'h3);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("arst_pre_pending", 32'(pending), 32'd3);
    Rst_n = 1'b0;
    #1;
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_RegWr", 32'(RegWr), 32'd0);
    chk("arst_Rw", 32'(Rw), 32'd0);
    chk("arst_busW", busW, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_ovf", 32'(ovf_err), 32'd0);
    mq.delete();
    movf = 0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom);
      Ra = 5'($urandom_range(0, 7));
      Rb = 5'($urandom_range(0, 7));
      #1;
      check_model();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
